// File: rtl/shreg_pkg.sv
// ----------------------------------------------------------------------------
// shreg_pkg
// Shared definitions for the universal shift register:
//   - opcode encodings OP_LOAD .. OP_NOP (3 bits)
//   - sequencer state encoding ST_IDLE / ST_SHIFT
//   - is_step_op(): true for opcodes that run through the step sequencer
// ----------------------------------------------------------------------------
package shreg_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_LOAD = 3'b000;
   localparam logic [OP_W-1:0] OP_SHL  = 3'b001;
   localparam logic [OP_W-1:0] OP_SHR  = 3'b010;
   localparam logic [OP_W-1:0] OP_ROL  = 3'b011;
   localparam logic [OP_W-1:0] OP_ROR  = 3'b100;
   localparam logic [OP_W-1:0] OP_ASR  = 3'b101;
   localparam logic [OP_W-1:0] OP_CLR  = 3'b110;
   localparam logic [OP_W-1:0] OP_NOP  = 3'b111;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Shift and rotate opcodes are the ones that consume a step count.
   function automatic logic is_step_op(input logic [OP_W-1:0] op);
      return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
             (op == OP_ROR) || (op == OP_ASR);
   endfunction

endpackage

// File: rtl/shift_step.sv
// ----------------------------------------------------------------------------
// shift_step
// Combinational single-step shifter: computes the register value after one
// step of the given operation.
// Ports:
//   value  in  N   current register contents
//   op     in  3   operation (only shift/rotate opcodes alter the value)
//   sin    in  1   serial fill bit for SHL / SHR
//   result out N   value after one step
// ----------------------------------------------------------------------------
module shift_step
   import shreg_pkg::*;
#(
   parameter int N = 16
) (
   input  logic [N-1:0]    value,
   input  logic [OP_W-1:0] op,
   input  logic            sin,
   output logic [N-1:0]    result
);

   always_comb begin
      // NOTE: default assigned first so every path drives result; no latch.
      result = value;
      case (op)
         OP_SHL:  result = {value[N-2:0], sin};
         OP_SHR:  result = {sin, value[N-1:1]};
         OP_ROL:  result = {value[N-2:0], value[N-1]};
         OP_ROR:  result = {value[0], value[N-1:1]};
         OP_ASR:  result = {value[N-1], value[N-1:1]};
         default: result = value;
      endcase
   end

endmodule

// File: rtl/univ_shiftreg.sv
// ----------------------------------------------------------------------------
// univ_shiftreg
// N-bit universal shift register with a multi-step sequencer. State updates
// on the falling clock edge; reset is asynchronous and active-high.
// Ports:
//   clk     in  1      clock (falling edge active)
//   rst     in  1      asynchronous active-high reset
//   start   in  1      command request, honoured only in IDLE
//   op      in  3      opcode, latched on accept
//   amt     in  CNT_W  step count for shift/rotate, latched on accept
//   din     in  N      parallel load data
//   sin     in  1      serial fill bit, sampled at every step edge
//   abort   in  1      ends an active shift without performing a step
//   dout    out N      register contents
//   sout_l  out 1      dout[N-1]
//   sout_r  out 1      dout[0]
//   busy    out 1      high while stepping
//   done    out 1      one-period completion pulse
// ----------------------------------------------------------------------------
module univ_shiftreg
   import shreg_pkg::*;
#(
   parameter int N     = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [OP_W-1:0]  op,
   input  logic [CNT_W-1:0] amt,
   input  logic [N-1:0]     din,
   input  logic             sin,
   input  logic             abort,
   output logic [N-1:0]     dout,
   output logic             sout_l,
   output logic             sout_r,
   output logic             busy,
   output logic             done
);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [OP_W-1:0]  op_q, op_nxt;
   logic [N-1:0]     dout_nxt;
   logic             done_nxt;
   logic [N-1:0]     step_val;

   shift_step #(.N(N)) u_step (
      .value  (dout),
      .op     (op_q),
      .sin    (sin),
      .result (step_val)
   );

   // Next-state and datapath decisions.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      op_nxt    = op_q;
      dout_nxt  = dout;
      done_nxt  = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start) begin
               done_nxt = 1'b1;
               case (op)
                  OP_LOAD: dout_nxt = din;
                  OP_CLR:  dout_nxt = '0;
                  default: begin
                     // A zero step count completes immediately like a NOP.
                     if (is_step_op(op) && (amt != '0)) begin
                        done_nxt  = 1'b0;
                        op_nxt    = op;
                        cnt_nxt   = amt;
                        state_nxt = ST_SHIFT;
                     end
                  end
               endcase
            end
         end

         ST_SHIFT: begin
            if (abort) begin
               // Leave with the partially shifted value; no step this edge.
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
               done_nxt  = 1'b1;
            end else begin
               dout_nxt = step_val;
               cnt_nxt  = cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state_nxt = ST_IDLE;
                  done_nxt  = 1'b1;
               end
            end
         end

         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         op_q  <= OP_NOP;
         dout  <= '0;
         done  <= 1'b0;
      end else begin
         // NOTE: non-blocking so all registers update from pre-edge values.
         state <= state_nxt;
         cnt   <= cnt_nxt;
         op_q  <= op_nxt;
         dout  <= dout_nxt;
         done  <= done_nxt;
      end
   end

   assign busy   = (state == ST_SHIFT);
   assign sout_l = dout[N-1];
   assign sout_r = dout[0];

endmodule
